// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the I/D cache memory arbiter.
// Port ids and FSM state encodings.
package cache_mem_arbiter_pkg;

  localparam logic ID_I = 1'b0;
  localparam logic ID_D = 1'b1;

  typedef enum logic {
    ARB   = 1'b0,
    WDATA = 1'b1
  } state_t;

endpackage

// File: rtl/cache_mem_arbiter_owner_fifo.sv
// Owner FIFO: 1-bit port id per outstanding read, in issue order.
// Ports: clk, reset, push/push_id, pop/pop_id, full, empty.
module owner_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic pop_id,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] slot;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_id  = slot[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        slot[wr_ptr] <= push_id;
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates I/D cache requests onto one memory port; routes read responses.
// Optional MEM_ARB_RR_EN: round-robin, else fixed priority D over I.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int MEM_ADDR_BITS   = 28,
  parameter int MEM_DATA_BITS   = 128,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_req_valid,
  output logic                       i_req_ready,
  input  logic [MEM_ADDR_BITS-1:0]   i_req_addr,
  input  logic                       i_req_rw,
  input  logic                       i_data_valid,
  output logic                       i_data_ready,
  input  logic [MEM_DATA_BITS-1:0]   i_data_bits,
  input  logic [MEM_DATA_BITS/8-1:0] i_data_mask,
  output logic                       i_resp_valid,
  output logic [MEM_DATA_BITS-1:0]   i_resp_data,
  input  logic                       d_req_valid,
  output logic                       d_req_ready,
  input  logic [MEM_ADDR_BITS-1:0]   d_req_addr,
  input  logic                       d_req_rw,
  input  logic                       d_data_valid,
  output logic                       d_data_ready,
  input  logic [MEM_DATA_BITS-1:0]   d_data_bits,
  input  logic [MEM_DATA_BITS/8-1:0] d_data_mask,
  output logic                       d_resp_valid,
  output logic [MEM_DATA_BITS-1:0]   d_resp_data,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
  output logic                       mem_req_rw,
  output logic                       mem_req_data_valid,
  input  logic                       mem_req_data_ready,
  output logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
  output logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                       mem_resp_valid,
  input  logic [MEM_DATA_BITS-1:0]   mem_resp_data,
  output logic                       orphan_err
);

  state_t state, state_nxt;
  logic   owner, owner_nxt;
  logic   sel, sel_valid, sel_rw;
  logic   dsel;
  logic   req_fire, data_fire;
  logic   push, pop, head_id;
  logic   full, empty;

`ifdef MEM_ARB_RR_EN
  logic rr_ptr, rr_nxt;
`endif

  owner_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .push_id(sel),
    .pop    (pop),
    .pop_id (head_id),
    .full   (full),
    .empty  (empty)
  );

  always_comb begin
`ifdef MEM_ARB_RR_EN
    if (d_req_valid && (!i_req_valid || rr_ptr == ID_D))
      sel = ID_D;
    else if (i_req_valid)
      sel = ID_I;
    else
      sel = rr_ptr;
`else
    sel = d_req_valid ? ID_D : ID_I;
`endif
  end

  assign sel_valid = (sel == ID_D) ? d_req_valid : i_req_valid;
  assign sel_rw    = (sel == ID_D) ? d_req_rw : i_req_rw;
  // Data follows the locked owner during a write, else the current winner.
  assign dsel      = (state == WDATA) ? owner : sel;

  assign i_resp_data = mem_resp_data;
  assign d_resp_data = mem_resp_data;

  always_comb begin
    state_nxt          = state;
    owner_nxt          = owner;
    mem_req_valid      = 1'b0;
    mem_req_addr       = (sel == ID_D) ? d_req_addr : i_req_addr;
    mem_req_rw         = sel_rw;
    i_req_ready        = 1'b0;
    d_req_ready        = 1'b0;
    mem_req_data_valid = 1'b0;
    mem_req_data_bits  = (dsel == ID_D) ? d_data_bits : i_data_bits;
    mem_req_data_mask  = (dsel == ID_D) ? d_data_mask : i_data_mask;
    i_data_ready       = 1'b0;
    d_data_ready       = 1'b0;
    i_resp_valid       = 1'b0;
    d_resp_valid       = 1'b0;
    req_fire           = 1'b0;
    data_fire          = 1'b0;
    push               = 1'b0;
    pop                = 1'b0;
    if (!reset) begin
      mem_req_data_valid =
        (dsel == ID_D) ? d_data_valid : i_data_valid;
      i_data_ready = (dsel == ID_I) & mem_req_data_ready;
      d_data_ready = (dsel == ID_D) & mem_req_data_ready;
      data_fire    = mem_req_data_valid & mem_req_data_ready;
      if (state == ARB) begin
        mem_req_valid = sel_valid & ~full;
        i_req_ready   = (sel == ID_I) & mem_req_ready & ~full;
        d_req_ready   = (sel == ID_D) & mem_req_ready & ~full;
        req_fire      = mem_req_valid & mem_req_ready;
        push          = req_fire & ~sel_rw;
        if (req_fire && sel_rw && !data_fire) begin
          state_nxt = WDATA;
          owner_nxt = sel;
        end
      end else if (data_fire) begin
        state_nxt = ARB;
      end
      pop          = mem_resp_valid & ~empty;
      i_resp_valid = pop & (head_id == ID_I);
      d_resp_valid = pop & (head_id == ID_D);
    end
  end

`ifdef MEM_ARB_RR_EN
  always_comb begin
    rr_nxt = rr_ptr;
    if (req_fire)
      rr_nxt = ~sel;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rr_ptr <= ID_D;
    else
      rr_ptr <= rr_nxt;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB;
      owner      <= ID_D;
      orphan_err <= 1'b0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      if (mem_resp_valid && empty)
        orphan_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter.
// Inputs driven 1ns after posedge, outputs checked on negedge.
module tb_cache_mem_arbiter;

  localparam int AB = 28;
  localparam int DB = 128;
  localparam int MB = DB / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req_valid, i_req_ready, i_req_rw;
  logic [AB-1:0] i_req_addr;
  logic          i_data_valid, i_data_ready;
  logic [DB-1:0] i_data_bits;
  logic [MB-1:0] i_data_mask;
  logic          i_resp_valid;
  logic [DB-1:0] i_resp_data;
  logic          d_req_valid, d_req_ready, d_req_rw;
  logic [AB-1:0] d_req_addr;
  logic          d_data_valid, d_data_ready;
  logic [DB-1:0] d_data_bits;
  logic [MB-1:0] d_data_mask;
  logic          d_resp_valid;
  logic [DB-1:0] d_resp_data;
  logic          mem_req_valid, mem_req_ready, mem_req_rw;
  logic [AB-1:0] mem_req_addr;
  logic          mem_req_data_valid, mem_req_data_ready;
  logic [DB-1:0] mem_req_data_bits;
  logic [MB-1:0] mem_req_data_mask;
  logic          mem_resp_valid;
  logic [DB-1:0] mem_resp_data;
  logic          orphan_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter dut (
    .clk               (clk),
    .reset             (reset),
    .i_req_valid       (i_req_valid),
    .i_req_ready       (i_req_ready),
    .i_req_addr        (i_req_addr),
    .i_req_rw          (i_req_rw),
    .i_data_valid      (i_data_valid),
    .i_data_ready      (i_data_ready),
    .i_data_bits       (i_data_bits),
    .i_data_mask       (i_data_mask),
    .i_resp_valid      (i_resp_valid),
    .i_resp_data       (i_resp_data),
    .d_req_valid       (d_req_valid),
    .d_req_ready       (d_req_ready),
    .d_req_addr        (d_req_addr),
    .d_req_rw          (d_req_rw),
    .d_data_valid      (d_data_valid),
    .d_data_ready      (d_data_ready),
    .d_data_bits       (d_data_bits),
    .d_data_mask       (d_data_mask),
    .d_resp_valid      (d_resp_valid),
    .d_resp_data       (d_resp_data),
    .mem_req_valid     (mem_req_valid),
    .mem_req_ready     (mem_req_ready),
    .mem_req_addr      (mem_req_addr),
    .mem_req_rw        (mem_req_rw),
    .mem_req_data_valid(mem_req_data_valid),
    .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits (mem_req_data_bits),
    .mem_req_data_mask (mem_req_data_mask),
    .mem_resp_valid    (mem_resp_valid),
    .mem_resp_data     (mem_resp_data),
    .orphan_err        (orphan_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_req_valid        = 1'b0;
    i_req_addr         = '0;
    i_req_rw           = 1'b0;
    i_data_valid       = 1'b0;
    i_data_bits        = '0;
    i_data_mask        = '0;
    d_req_valid        = 1'b0;
    d_req_addr         = '0;
    d_req_rw           = 1'b0;
    d_data_valid       = 1'b0;
    d_data_bits        = '0;
    d_data_mask        = '0;
    mem_req_ready      = 1'b1;
    mem_req_data_ready = 1'b1;
    mem_resp_valid     = 1'b0;
    mem_resp_data      = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    d_req_valid    = 1'b1;
    mem_resp_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mem_valid got=%b exp=0", mem_req_valid);
    end
    checks++;
    if ({i_req_ready, d_req_ready} !== 2'b00) begin
      errors++;
      $display("FAIL rst_ready got=%b exp=00",
               {i_req_ready, d_req_ready});
    end
    checks++;
    if ({i_resp_valid, d_resp_valid, orphan_err} !== 3'b000) begin
      errors++;
      $display("FAIL rst_resp got=%b exp=000",
               {i_resp_valid, d_resp_valid, orphan_err});
    end
    idle();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    logic [DB-1:0] rd;
    rd          = {16{8'hA5}};
    d_req_valid = 1'b1;
    d_req_addr  = 28'h0000010;
    d_req_rw    = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_req_valid, d_req_ready, i_req_ready} !== 3'b110) begin
      errors++;
      $display("FAIL rd_issue got=%b exp=110",
               {mem_req_valid, d_req_ready, i_req_ready});
    end
    checks++;
    if (mem_req_addr !== 28'h0000010 || mem_req_rw !== 1'b0) begin
      errors++;
      $display("FAIL rd_addr got=%h/%b exp=0000010/0",
               mem_req_addr, mem_req_rw);
    end
    tick();
    d_req_valid = 1'b0;
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_data  = rd;
    @(negedge clk);
    checks++;
    if ({d_resp_valid, i_resp_valid} !== 2'b10) begin
      errors++;
      $display("FAIL rd_route got=%b exp=10",
               {d_resp_valid, i_resp_valid});
    end
    checks++;
    if (d_resp_data !== rd) begin
      errors++;
      $display("FAIL rd_data got=%h exp=%h", d_resp_data, rd);
    end
    tick();
    mem_resp_valid = 1'b0;
  endtask

  task automatic test_both();
    i_req_addr  = 28'h0000100;
    d_req_addr  = 28'h0000200;
`ifdef MEM_ARB_RR_EN
    begin
      logic w, pw;
      pw = 1'b0;
      i_req_valid = 1'b1;
      d_req_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
        w = (k % 2 == 0) ? 1'b0 : 1'b1;
        mem_resp_valid = (k > 0);
        @(negedge clk);
        checks++;
        if ({d_req_ready, i_req_ready} !== {w, ~w}) begin
          errors++;
          $display("FAIL rr_win k=%0d got=%b exp=%b", k,
                   {d_req_ready, i_req_ready}, {w, ~w});
        end
        if (k > 0) begin
          checks++;
          if ({d_resp_valid, i_resp_valid} !== {pw, ~pw}) begin
            errors++;
            $display("FAIL rr_resp k=%0d got=%b exp=%b", k,
                     {d_resp_valid, i_resp_valid}, {pw, ~pw});
          end
        end
        pw = w;
        tick();
      end
      i_req_valid    = 1'b0;
      d_req_valid    = 1'b0;
      mem_resp_valid = 1'b1;
      @(negedge clk);
      checks++;
      if ({d_resp_valid, i_resp_valid} !== 2'b10) begin
        errors++;
        $display("FAIL rr_last got=%b exp=10",
                 {d_resp_valid, i_resp_valid});
      end
      tick();
      mem_resp_valid = 1'b0;
    end
`else
    i_req_valid = 1'b1;
    d_req_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({d_req_ready, i_req_ready} !== 2'b10 ||
        mem_req_addr !== 28'h0000200) begin
      errors++;
      $display("FAIL fp_first got=%b/%h exp=10/0000200",
               {d_req_ready, i_req_ready}, mem_req_addr);
    end
    tick();
    d_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({d_req_ready, i_req_ready} !== 2'b01 ||
        mem_req_addr !== 28'h0000100) begin
      errors++;
      $display("FAIL fp_second got=%b/%h exp=01/0000100",
               {d_req_ready, i_req_ready}, mem_req_addr);
    end
    tick();
    i_req_valid    = 1'b0;
    mem_resp_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({d_resp_valid, i_resp_valid} !== 2'b10) begin
      errors++;
      $display("FAIL fp_resp0 got=%b exp=10",
               {d_resp_valid, i_resp_valid});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({d_resp_valid, i_resp_valid} !== 2'b01) begin
      errors++;
      $display("FAIL fp_resp1 got=%b exp=01",
               {d_resp_valid, i_resp_valid});
    end
    tick();
    mem_resp_valid = 1'b0;
`endif
  endtask

  task automatic test_write_late();
    d_req_valid = 1'b1;
    d_req_addr  = 28'h0000300;
    d_req_rw    = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_req_valid, mem_req_rw, d_req_ready} !== 3'b111 ||
        mem_req_addr !== 28'h0000300) begin
      errors++;
      $display("FAIL wr_issue got=%b/%h exp=111/0000300",
               {mem_req_valid, mem_req_rw, d_req_ready},
               mem_req_addr);
    end
    tick();
    d_req_valid  = 1'b0;
    d_req_rw     = 1'b0;
    d_data_valid = 1'b1;
    d_data_bits  = {4{32'hDEADBEEF}};
    d_data_mask  = 16'hFFFF;
    i_req_valid  = 1'b1;
    i_req_addr   = 28'h0000400;
    @(negedge clk);
    checks++;
    if ({i_req_ready, mem_req_valid} !== 2'b00) begin
      errors++;
      $display("FAIL wr_block got=%b exp=00",
               {i_req_ready, mem_req_valid});
    end
    checks++;
    if ({mem_req_data_valid, d_data_ready} !== 2'b11 ||
        mem_req_data_bits !== {4{32'hDEADBEEF}}) begin
      errors++;
      $display("FAIL wr_beat got=%b/%h exp=11/deadbeef..",
               {mem_req_data_valid, d_data_ready},
               mem_req_data_bits);
    end
    tick();
    d_data_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({i_req_ready, mem_req_valid} !== 2'b11 ||
        mem_req_addr !== 28'h0000400) begin
      errors++;
      $display("FAIL wr_after got=%b/%h exp=11/0000400",
               {i_req_ready, mem_req_valid}, mem_req_addr);
    end
    tick();
    i_req_valid    = 1'b0;
    mem_resp_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({d_resp_valid, i_resp_valid} !== 2'b01) begin
      errors++;
      $display("FAIL wr_iresp got=%b exp=01",
               {d_resp_valid, i_resp_valid});
    end
    tick();
    mem_resp_valid = 1'b0;
  endtask

  task automatic test_full();
    i_req_valid = 1'b1;
    i_req_rw    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_req_addr = 28'h0000500 + AB'(k);
      @(negedge clk);
      checks++;
      if (i_req_ready !== 1'b1) begin
        errors++;
        $display("FAIL full_fill k=%0d got=%b exp=1", k, i_req_ready);
      end
      tick();
    end
    i_req_addr = 28'h0000504;
    @(negedge clk);
    checks++;
    if ({i_req_ready, mem_req_valid} !== 2'b00) begin
      errors++;
      $display("FAIL full_block got=%b exp=00",
               {i_req_ready, mem_req_valid});
    end
    tick();
    mem_resp_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({i_req_ready, i_resp_valid} !== 2'b01) begin
      errors++;
      $display("FAIL full_pop got=%b exp=01",
               {i_req_ready, i_resp_valid});
    end
    tick();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({i_req_ready, mem_req_valid} !== 2'b11 ||
        mem_req_addr !== 28'h0000504) begin
      errors++;
      $display("FAIL full_next got=%b/%h exp=11/0000504",
               {i_req_ready, mem_req_valid}, mem_req_addr);
    end
    tick();
    i_req_valid    = 1'b0;
    mem_resp_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({i_resp_valid, orphan_err} !== 2'b10) begin
        errors++;
        $display("FAIL full_drain k=%0d got=%b exp=10", k,
                 {i_resp_valid, orphan_err});
      end
      tick();
    end
    mem_resp_valid = 1'b0;
  endtask

  task automatic test_orphan();
    mem_resp_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({i_resp_valid, d_resp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL orph_resp got=%b exp=00",
               {i_resp_valid, d_resp_valid});
    end
    tick();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (orphan_err !== 1'b1) begin
      errors++;
      $display("FAIL orph_set got=%b exp=1", orphan_err);
    end
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (orphan_err !== 1'b1) begin
      errors++;
      $display("FAIL orph_sticky got=%b exp=1", orphan_err);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    d_req_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      d_req_addr = 28'h0000600 + AB'(k);
      @(negedge clk);
      checks++;
      if (d_req_ready !== 1'b1) begin
        errors++;
        $display("FAIL rm_read k=%0d got=%b exp=1", k, d_req_ready);
      end
      tick();
    end
    d_req_addr = 28'h0000700;
    d_req_rw   = 1'b1;
    tick();
    d_req_valid = 1'b0;
    d_req_rw    = 1'b0;
    i_req_valid = 1'b1;
    i_req_addr  = 28'h0000800;
    @(negedge clk);
    checks++;
    if (i_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rm_locked got=%b exp=0", i_req_ready);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({orphan_err, i_req_ready, mem_req_valid} !== 3'b000) begin
      errors++;
      $display("FAIL rm_clear got=%b exp=000",
               {orphan_err, i_req_ready, mem_req_valid});
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({i_req_ready, mem_req_valid} !== 2'b11 ||
        mem_req_addr !== 28'h0000800) begin
      errors++;
      $display("FAIL rm_iread got=%b/%h exp=11/0000800",
               {i_req_ready, mem_req_valid}, mem_req_addr);
    end
    tick();
    i_req_valid    = 1'b0;
    mem_resp_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({d_resp_valid, i_resp_valid} !== 2'b01) begin
      errors++;
      $display("FAIL rm_iresp got=%b exp=01",
               {d_resp_valid, i_resp_valid});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({d_resp_valid, i_resp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL rm_stale got=%b exp=00",
               {d_resp_valid, i_resp_valid});
    end
    tick();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (orphan_err !== 1'b1) begin
      errors++;
      $display("FAIL rm_orphan got=%b exp=1", orphan_err);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_both();
    test_write_late();
    test_full();
    test_orphan();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
